dmi_req_arbiter: RTL and testbench
==================================

Name: dmi_req_arbiter

Overview:
- Shares the single downstream DMI request/response port between two debug requesters: port 0 is the JTAG DTM, port 1 is the secure debug mailbox.
- Grants are round-robin. A granted transaction owns the port until its response is delivered.
- Writes are gated by a per-requester unlock input. Forbidden and reserved ops get a local error response.
- A response watchdog recovers the port if the downstream side never answers.
- Sits between the DTM/mailbox and the dmi_cdc core-side request port.

Parameters:
- TIMEOUT, 255: cycles in WAIT before a watchdog error response. 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous and active-high.
- req0_i  in  41  requester 0 request: {addr[40:34], op[33:32], data[31:0]}. op: 0=nop, 1=read, 2=write, 3=reserved.
- req0_valid_i  in  1  requester 0 request valid.
- req0_ready_o  out  1  requester 0 request accepted.
- resp0_o  out  34  response to requester 0: {data[33:2], resp[1:0]}. resp: 0=ok, 2=denied, 3=timeout.
- resp0_valid_o  out  1  response valid for requester 0.
- resp0_ready_i  in  1  requester 0 response ready.
- unlock0_i  in  1  requester 0 may issue writes.
- req1_i, req1_valid_i, req1_ready_o, resp1_o, resp1_valid_o, resp1_ready_i, unlock1_i: same widths and meanings as port 0, for requester 1.
- dmi_req_o  out  41  downstream request.
- dmi_req_valid_o  out  1  downstream request valid.
- dmi_req_ready_i  in  1  downstream request ready.
- dmi_resp_i  in  34  downstream response.
- dmi_resp_valid_i  in  1  downstream response valid.
- dmi_resp_ready_o  out  1  downstream response ready.
- grant_o  out  2  one-hot current owner; 0 when in IDLE.
- busy_o  out  1  state is not IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- State machine: IDLE, ISSUE, WAIT, RESP, DRAIN.
- Reset (asynchronous, active-high):
  - state=IDLE, last=1 (so port 0 wins the first tie), counter=0.
  - req/resp registers cleared.
  - All outputs 0.
- IDLE, winner selection:
  - A single valid requester wins.
  - Both valid: the requester that is not `last` wins.
  - reqN_ready_o=1 combinationally for the winner only, in IDLE only.
- IDLE, on acceptance (same cycle):
  - Capture the request into req_q and the owner into own_q; set last=winner.
  - Forbidden request (op==2 with unlockN_i=0 sampled at acceptance, or op==3): resp_q={32'h0, 2'h2}, next state RESP. No downstream traffic.
  - Otherwise: next state ISSUE.
- ISSUE:
  - dmi_req_o=req_q, dmi_req_valid_o=1.
  - On dmi_req_ready_i: next state WAIT, counter=0.
  - Minimum latency: acceptance to dmi_req_valid_o is 1 cycle.
- WAIT:
  - dmi_resp_ready_o=1.
  - On dmi_resp_valid_i: resp_q=dmi_resp_i, next state RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with TIMEOUT≠0: resp_q={32'h0, 2'h3}, timeout_o=1 for that cycle, next state RESP, drain flag set.
  - If dmi_resp_valid_i and the timeout coincide in the same cycle, the real response wins and no timeout is raised.
- RESP:
  - resp{own}_o=resp_q, resp{own}_valid_o=1.
  - On resp{own}_ready_i: next state DRAIN if the drain flag is set, else IDLE.
  - Response outputs of the non-owner are 0.
- DRAIN:
  - dmi_resp_ready_o=1. The late downstream response is discarded, then next state IDLE. The drain flag is cleared.
- grant_o=onehot(own_q) in ISSUE, WAIT, RESP and DRAIN.
- Back-to-back: a new grant is possible in the cycle state returns to IDLE. There is no accept during RESP.
- unlockN_i changes after acceptance do not affect an in-flight transaction.
- Reset mid-transaction returns to IDLE immediately. No response is produced for the aborted transaction.
- dmi_resp_valid_i outside WAIT/DRAIN is ignored; dmi_resp_ready_o=0 in those states.

Test Plan:
- Port 0 read only: req0 {addr=7'h11, op=1}, downstream ready next cycle, resp {32'hCAFEF00D, 0} two cycles later. Expect: req0_ready_o in cycle 0, dmi_req_valid_o in cycle 1, resp0_o=={32'hCAFEF00D, 2'h0} presented and held until resp0_ready_i.
- Both requesters valid continuously, 4 reads each. Expect grants 0,1,0,1,... and each response routed only to its own port.
- Write gating: req1 op=2 with unlock1_i=0. Expect resp1_o={0, 2'h2}, dmi_req_valid_o never asserted. Repeat with unlock1_i=1: the write is forwarded with data intact.
- Reserved op: req0 op=3. Expect a local 2'h2 response and no downstream traffic.
- Watchdog: TIMEOUT=4, downstream never responds. Expect timeout_o pulse 4 cycles after entering WAIT and resp0_o={0, 2'h3}. Then inject a late downstream response: it is consumed in DRAIN, not forwarded, and the next request proceeds normally.
- Reset asserted during WAIT. Expect all outputs 0 asynchronously and IDLE after release; a following request is granted to port 0 on a tie.

Source files
------------

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI request/response port between the JTAG DTM (port 0) and the secure mailbox (port 1).
// Round-robin grant; one transaction in flight; write gating, local error responses and a response watchdog.
module dmi_req_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [40:0] req0_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    output logic [33:0] resp0_o,
    output logic        resp0_valid_o,
    input  logic        resp0_ready_i,
    input  logic        unlock0_i,
    input  logic [40:0] req1_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    output logic [33:0] resp1_o,
    output logic        resp1_valid_o,
    input  logic        resp1_ready_i,
    input  logic        unlock1_i,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    state_t            state, state_nxt;
    logic              own_q, last_q, drain_q;
    logic [40:0]       req_q;
    logic [33:0]       resp_q;
    logic [CNT_W-1:0]  cnt_q;

    logic        both_vld, any_vld, win, win_unlock, forbidden, own_resp_ready;
    logic [40:0] win_req;
    logic        accept, resp_load, cnt_clr, cnt_inc, drain_set, drain_clr;
    logic [33:0] resp_nxt;

    // With both requesters valid, the one that did not win last time goes next.
    assign both_vld       = req0_valid_i & req1_valid_i;
    assign any_vld        = req0_valid_i | req1_valid_i;
    assign win            = both_vld ? ~last_q : req1_valid_i;
    assign win_req        = win ? req1_i : req0_i;
    assign win_unlock     = win ? unlock1_i : unlock0_i;
    assign forbidden      = (win_req[33:32] == 2'd3) || ((win_req[33:32] == 2'd2) && !win_unlock);
    assign own_resp_ready = own_q ? resp1_ready_i : resp0_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        accept           = 1'b0;
        resp_load        = 1'b0;
        resp_nxt         = '0;
        cnt_clr          = 1'b0;
        cnt_inc          = 1'b0;
        drain_set        = 1'b0;
        drain_clr        = 1'b0;
        req0_ready_o     = 1'b0;
        req1_ready_o     = 1'b0;
        resp0_o          = '0;
        resp0_valid_o    = 1'b0;
        resp1_o          = '0;
        resp1_valid_o    = 1'b0;
        dmi_req_o        = '0;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        timeout_o        = 1'b0;
        busy_o           = (state != IDLE);
        grant_o          = (state == IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);
        case (state)
            IDLE: begin
                // Ready is held low while reset is asserted so all outputs read 0.
                if (any_vld && !rst_i) begin
                    accept       = 1'b1;
                    req0_ready_o = !win;
                    req1_ready_o = win;
                    if (forbidden) begin
                        resp_load = 1'b1;
                        resp_nxt  = {32'h0, 2'd2};
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                dmi_req_o       = req_q;
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) begin
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    resp_load = 1'b1;
                    resp_nxt  = dmi_resp_i;
                    state_nxt = RESP;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    resp_load = 1'b1;
                    resp_nxt  = {32'h0, 2'd3};
                    timeout_o = 1'b1;
                    drain_set = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (own_q) begin
                    resp1_o       = resp_q;
                    resp1_valid_o = 1'b1;
                end else begin
                    resp0_o       = resp_q;
                    resp0_valid_o = 1'b1;
                end
                if (own_resp_ready) state_nxt = drain_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                // The abandoned transaction's late response is swallowed here.
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    drain_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q   <= '0;
            resp_q  <= '0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            drain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                req_q  <= win_req;
                own_q  <= win;
                last_q <= win;
            end
            if (resp_load) resp_q <= resp_nxt;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (drain_set)      drain_q <= 1'b1;
            else if (drain_clr) drain_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Self-checking bench for dmi_req_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_dmi_req_arbiter;
    localparam int TO = 4;
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_RESP = 3, PH_DRAIN = 4;

    logic clk = 1'b0;
    logic rst;
    logic [40:0] req0_i, req1_i, dmi_req_o;
    logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [33:0] resp0_o, resp1_o, dmi_resp_i;
    logic        resp0_valid_o, resp1_valid_o, resp0_ready_i, resp1_ready_i;
    logic        unlock0_i, unlock1_i;
    logic        dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
    logic [1:0]  grant_o;
    logic        busy_o, timeout_o;

    always #5 clk = ~clk;

    dmi_req_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0_i), .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .resp0_o(resp0_o), .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .unlock0_i(unlock0_i),
        .req1_i(req1_i), .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .resp1_o(resp1_o), .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .unlock1_i(unlock1_i),
        .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    // Transaction-level model: which phase the single in-flight transaction is in and who owns it.
    int          m_phase, m_owner, m_wcnt;
    bit          m_last, m_drain;
    logic [40:0] m_req;
    logic [33:0] m_resp;

    function automatic int pick_winner();
        if (req0_valid_i && req1_valid_i) return m_last ? 0 : 1;
        if (req0_valid_i) return 0;
        if (req1_valid_i) return 1;
        return -1;
    endfunction

    function automatic logic [40:0] winner_req();
        return (pick_winner() == 1) ? req1_i : req0_i;
    endfunction

    function automatic bit is_forbidden();
        logic [40:0] r;
        bit unl;
        r   = winner_req();
        unl = (pick_winner() == 1) ? unlock1_i : unlock0_i;
        return (r[33:32] == 2'd3) || (r[33:32] == 2'd2 && !unl);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= PH_IDLE; m_owner <= 0; m_wcnt <= 0;
            m_last  <= 1'b1;    m_drain <= 1'b0;
            m_req   <= '0;      m_resp  <= '0;
        end else begin
            case (m_phase)
                PH_IDLE: if (pick_winner() >= 0) begin
                    m_owner <= pick_winner();
                    m_last  <= (pick_winner() == 1);
                    m_req   <= winner_req();
                    m_resp  <= {32'h0, 2'd2};
                    m_phase <= is_forbidden() ? PH_RESP : PH_ISSUE;
                end
                PH_ISSUE: if (dmi_req_ready_i) begin
                    m_phase <= PH_WAIT;
                    m_wcnt  <= 0;
                end
                PH_WAIT: begin
                    if (dmi_resp_valid_i) begin
                        m_resp <= dmi_resp_i; m_phase <= PH_RESP;
                    end else if (TO != 0 && m_wcnt == TO - 1) begin
                        m_resp <= {32'h0, 2'd3}; m_phase <= PH_RESP; m_drain <= 1'b1;
                    end else begin
                        m_wcnt <= m_wcnt + 1;
                    end
                end
                PH_RESP: if ((m_owner == 0) ? resp0_ready_i : resp1_ready_i)
                    m_phase <= m_drain ? PH_DRAIN : PH_IDLE;
                PH_DRAIN: if (dmi_resp_valid_i) begin
                    m_phase <= PH_IDLE; m_drain <= 1'b0;
                end
                default: m_phase <= PH_IDLE;
            endcase
        end
    end

    logic [40:0] e_dmi_req;
    logic [33:0] e_resp0, e_resp1;
    logic        e_rdy0, e_rdy1, e_dmi_vld, e_dmi_rrdy, e_rv0, e_rv1, e_busy, e_to;
    logic [1:0]  e_grant;
    int          n_chk = 0, n_pass = 0;

    function automatic void compute_exp();
        e_dmi_req = '0; e_resp0 = '0; e_resp1 = '0; e_rdy0 = 0; e_rdy1 = 0;
        e_dmi_vld = 0; e_dmi_rrdy = 0; e_rv0 = 0; e_rv1 = 0; e_busy = 0; e_to = 0; e_grant = 2'b00;
        if (rst) return;
        case (m_phase)
            PH_IDLE:  begin e_rdy0 = (pick_winner() == 0); e_rdy1 = (pick_winner() == 1); end
            PH_ISSUE: begin e_dmi_req = m_req; e_dmi_vld = 1; end
            PH_WAIT:  begin
                e_dmi_rrdy = 1;
                e_to = (TO != 0) && !dmi_resp_valid_i && (m_wcnt == TO - 1);
            end
            PH_RESP:  if (m_owner == 0) begin e_resp0 = m_resp; e_rv0 = 1; end
                      else begin e_resp1 = m_resp; e_rv1 = 1; end
            PH_DRAIN: e_dmi_rrdy = 1;
            default:  ;
        endcase
        if (m_phase != PH_IDLE) begin
            e_busy  = 1;
            e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_all();
        compute_exp();
        chk("req0_ready", 64'(req0_ready_o), 64'(e_rdy0));
        chk("req1_ready", 64'(req1_ready_o), 64'(e_rdy1));
        chk("resp0", 64'(resp0_o), 64'(e_resp0));
        chk("resp0_valid", 64'(resp0_valid_o), 64'(e_rv0));
        chk("resp1", 64'(resp1_o), 64'(e_resp1));
        chk("resp1_valid", 64'(resp1_valid_o), 64'(e_rv1));
        chk("dmi_req", 64'(dmi_req_o), 64'(e_dmi_req));
        chk("dmi_req_valid", 64'(dmi_req_valid_o), 64'(e_dmi_vld));
        chk("dmi_resp_ready", 64'(dmi_resp_ready_o), 64'(e_dmi_rrdy));
        chk("grant", 64'(grant_o), 64'(e_grant));
        chk("busy", 64'(busy_o), 64'(e_busy));
        chk("timeout", 64'(timeout_o), 64'(e_to));
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req0_valid_i = 0; req1_valid_i = 0;
            dmi_req_ready_i = 1; dmi_resp_valid_i = 1;
            resp0_ready_i = 1; resp1_ready_i = 1;
            settle();
        end
        dmi_resp_valid_i = 0;
    endtask

    // Drives one request to completion with an always-ready, always-answering downstream.
    task automatic run_txn(input bit port, input logic [40:0] rq, input bit unl, input logic [33:0] dresp,
                           output logic [33:0] got, output bit saw_dmi, output logic [40:0] dmi_seen, output bit ok);
        bit accepted = 0;
        got = '0; saw_dmi = 0; dmi_seen = '0; ok = 0;
        dmi_req_ready_i = 1; dmi_resp_i = dresp; resp0_ready_i = 1; resp1_ready_i = 1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (port) begin req1_i = rq; req1_valid_i = !accepted; unlock1_i = accepted ? !unl : unl; end
            else      begin req0_i = rq; req0_valid_i = !accepted; unlock0_i = accepted ? !unl : unl; end
            dmi_resp_valid_i = 1;
            settle();
            if (port ? (req1_valid_i && req1_ready_o) : (req0_valid_i && req0_ready_o)) accepted = 1;
            if (dmi_req_valid_o) begin saw_dmi = 1; dmi_seen = dmi_req_o; end
            if (port ? resp1_valid_o : resp0_valid_o) begin got = port ? resp1_o : resp0_o; ok = 1; end
        end
        idle_cycles(2);
    endtask

    initial begin
        logic [33:0] got;
        logic [40:0] dseen;
        logic [63:0] r64;
        bit          saw, ok;
        int          acc0, acc1, prev, g, to_at;

        rst = 1; req0_i = '0; req1_i = '0; req0_valid_i = 0; req1_valid_i = 0;
        resp0_ready_i = 0; resp1_ready_i = 0; unlock0_i = 0; unlock1_i = 0;
        dmi_req_ready_i = 0; dmi_resp_i = '0; dmi_resp_valid_i = 0;
        @(negedge clk); req0_valid_i = 1; settle();
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_ready0", 64'(req0_ready_o), 0);
        @(negedge clk); rst = 0; req0_valid_i = 0; settle();

        // Port 0 read with literal timing.
        @(negedge clk); req0_i = {7'h11, 2'd1, 32'h0}; req0_valid_i = 1; settle();
        chk("t1_ready0", 64'(req0_ready_o), 1);
        @(negedge clk); req0_valid_i = 0; dmi_req_ready_i = 1; settle();
        chk("t1_dmi_valid", 64'(dmi_req_valid_o), 1);
        chk("t1_dmi_req", 64'(dmi_req_o), 64'({7'h11, 2'd1, 32'h0}));
        @(negedge clk); dmi_req_ready_i = 0; settle();
        @(negedge clk); dmi_resp_valid_i = 1; dmi_resp_i = {32'hCAFEF00D, 2'd0}; settle();
        @(negedge clk); dmi_resp_valid_i = 0; resp0_ready_i = 0; settle();
        chk("t1_resp0", 64'(resp0_o), 64'({32'hCAFEF00D, 2'd0}));
        @(negedge clk); resp0_ready_i = 1; settle();
        chk("t1_resp0_held", 64'(resp0_o), 64'({32'hCAFEF00D, 2'd0}));
        @(negedge clk); resp0_ready_i = 0; settle();
        chk("t1_idle", 64'(busy_o), 0);

        // Both requesters continuously valid: strict alternation, port 1 first since port 0 won last.
        acc0 = 0; acc1 = 0; prev = -1;
        dmi_req_ready_i = 1; dmi_resp_valid_i = 1; resp0_ready_i = 1; resp1_ready_i = 1;
        for (int c = 0; c < 200 && (acc0 < 4 || acc1 < 4); c++) begin
            @(negedge clk);
            req0_valid_i = (acc0 < 4); req1_valid_i = (acc1 < 4);
            req0_i = {7'(acc0), 2'd1, 32'h0}; req1_i = {7'(acc1 + 64), 2'd1, 32'h0};
            dmi_resp_i = {32'(c), 2'd0};
            settle();
            g = -1;
            if (req0_valid_i && req0_ready_o) begin g = 0; acc0++; end
            else if (req1_valid_i && req1_ready_o) begin g = 1; acc1++; end
            if (g >= 0) begin
                if (prev < 0) chk("t2_first_grant", 64'(g), 1);
                else          chk("t2_alternate", 64'(g), 64'(1 - prev));
                prev = g;
            end
        end
        chk("t2_accepts", 64'(acc0 + acc1), 8);
        idle_cycles(4);

        // Write gating and reserved op.
        run_txn(1, {7'h22, 2'd2, 32'h12345678}, 0, {32'h5555AAAA, 2'd0}, got, saw, dseen, ok);
        chk("t3_locked_done", 64'(ok), 1);
        chk("t3_locked_resp", 64'(got), 64'({32'h0, 2'd2}));
        chk("t3_locked_no_dmi", 64'(saw), 0);
        run_txn(1, {7'h22, 2'd2, 32'h12345678}, 1, {32'h5555AAAA, 2'd0}, got, saw, dseen, ok);
        chk("t3_unlocked_resp", 64'(got), 64'({32'h5555AAAA, 2'd0}));
        chk("t3_unlocked_dmi", 64'(dseen), 64'({7'h22, 2'd2, 32'h12345678}));
        run_txn(0, {7'h05, 2'd3, 32'hFFFF0000}, 1, {32'h11112222, 2'd0}, got, saw, dseen, ok);
        chk("t4_reserved_resp", 64'(got), 64'({32'h0, 2'd2}));
        chk("t4_reserved_no_dmi", 64'(saw), 0);

        // Watchdog: downstream accepts but never answers.
        @(negedge clk); req0_i = {7'h33, 2'd1, 32'h0}; req0_valid_i = 1;
        dmi_req_ready_i = 1; dmi_resp_valid_i = 0; resp0_ready_i = 0; settle();
        @(negedge clk); req0_valid_i = 0; settle();
        to_at = 0;
        for (int w = 1; w <= 10 && to_at == 0; w++) begin
            @(negedge clk); settle();
            if (timeout_o) to_at = w;
        end
        chk("t5_timeout_cycle", 64'(to_at), 4);
        @(negedge clk); resp0_ready_i = 1; settle();
        chk("t5_pulse_once", 64'(timeout_o), 0);
        chk("t5_resp0", 64'(resp0_o), 64'({32'h0, 2'd3}));
        @(negedge clk); resp0_ready_i = 0; req1_i = {7'h01, 2'd1, 32'h0}; req1_valid_i = 1; settle();
        chk("t5_drain_busy", 64'(busy_o), 1);
        chk("t5_drain_no_accept", 64'(req1_ready_o), 0);
        @(negedge clk); req1_valid_i = 0; dmi_resp_valid_i = 1; dmi_resp_i = {32'hDEADBEEF, 2'd0}; settle();
        chk("t5_late_not_fwd", 64'(resp0_valid_o), 0);
        @(negedge clk); dmi_resp_valid_i = 0; settle();
        chk("t5_back_idle", 64'(busy_o), 0);
        run_txn(0, {7'h34, 2'd1, 32'h0}, 1, {32'h0BADF00D, 2'd0}, got, saw, dseen, ok);
        chk("t5_next_ok", 64'(got), 64'({32'h0BADF00D, 2'd0}));

        // Reset while waiting on downstream.
        @(negedge clk); req0_i = {7'h40, 2'd1, 32'h0}; req0_valid_i = 1;
        dmi_req_ready_i = 1; dmi_resp_valid_i = 0; settle();
        @(negedge clk); req0_valid_i = 0; settle();
        @(negedge clk); settle();
        chk("t6_in_wait", 64'(dmi_resp_ready_o), 1);
        #2; rst = 1; #1;
        compare_all();
        chk("t6_rst_busy", 64'(busy_o), 0);
        chk("t6_rst_grant", 64'(grant_o), 0);
        chk("t6_rst_dmi_rrdy", 64'(dmi_resp_ready_o), 0);
        @(negedge clk); settle();
        @(negedge clk); rst = 0; req0_valid_i = 1; req1_valid_i = 1;
        req1_i = {7'h41, 2'd1, 32'h0}; settle();
        chk("t6_tie_port0", 64'(req0_ready_o), 1);
        chk("t6_tie_not1", 64'(req1_ready_o), 0);

        // Randomized traffic against the model, including occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = (!rst && $urandom_range(0, 599) == 0);
            req0_valid_i = ($urandom_range(0, 2) != 0);
            req1_valid_i = ($urandom_range(0, 2) != 0);
            r64 = {$urandom(), $urandom()}; req0_i = r64[40:0];
            r64 = {$urandom(), $urandom()}; req1_i = r64[40:0];
            r64 = {$urandom(), $urandom()}; dmi_resp_i = r64[33:0];
            unlock0_i = 1'($urandom_range(0, 1)); unlock1_i = 1'($urandom_range(0, 1));
            dmi_req_ready_i = 1'($urandom_range(0, 1));
            dmi_resp_valid_i = ($urandom_range(0, 9) < 3);
            resp0_ready_i = 1'($urandom_range(0, 1)); resp1_ready_i = 1'($urandom_range(0, 1));
            settle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
